// File: rtl/mux2_stim_pkg.sv
// Purpose : shared types, constants and the LFSR step function for the Mux_2 stimulus stage.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   stim_state_t  - generator FSM states IDLE / RUN / DONE
//   LFSR_W        - LFSR width (8)
//   LFSR_TAPS     - feedback tap mask, bits 7,5,4,3 (x^8+x^6+x^5+x^4+1)
//   DEFAULT_SEED  - reset value of the LFSR and fallback for a zero seed
//   lfsr_step()   - one Fibonacci shift; also usable by a checker to predict vectors
package mux2_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stim_state_t;

    localparam int               LFSR_W       = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01;

    // Shift left, feedback (XOR of the tapped bits) enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mux2_lfsr.sv
// Purpose : 8-bit Fibonacci LFSR register with synchronous load and advance.
// Latency : load/advance take effect on the next rising edge of clk.
// Backpressure: none; the caller holds the state by keeping advance low.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset, state returns to DEFAULT_SEED
//   load    - load seed (wins over advance)
//   seed    - value loaded on load
//   advance - step the sequence by one
//   state   - current LFSR contents (registered)
module mux2_lfsr
    import mux2_stim_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (advance) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DEFAULT_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/mux2_stim_gen.sv
// Purpose : emits a bounded run of 3-bit (A,B,C) vectors for Mux_2 from an 8-bit LFSR.
// Latency : start sampled at edge t -> vector 0 valid after edge t; Out_Done after the last accept.
// Backpressure: In_Ready low holds vector, Out_Iter and LFSR; start ignored outside IDLE.
//
// Optional feature: define MUX2_STIM_EXHAUSTIVE_EN to prepend a binary sweep
// 000..111 (taken from Out_Iter[2:0]) to every run; the LFSR stays at its seed
// during the sweep and supplies vectors from iteration 8 onward.
//
// Ports:
//   In_Clk, In_Rst        - clock, synchronous active-high reset
//   In_Start              - start pulse, honoured only in IDLE
//   In_Num_Iter           - vectors in the run, latched at start (0 -> straight to DONE)
//   In_Ready              - downstream accepts the current vector
//   Out_A/Out_B/Out_C     - vector bits 2/1/0
//   Out_Valid             - vector valid (RUN only)
//   Out_Iter              - 0-based index of the current vector
//   Out_Busy              - FSM not in IDLE
//   Out_Done              - single-cycle pulse after the final acceptance
module mux2_stim_gen
    import mux2_stim_pkg::*;
#(
    parameter int                ITER_W = 8,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic              In_Clk,
    input  logic              In_Rst,
    input  logic              In_Start,
    input  logic [ITER_W-1:0] In_Num_Iter,
    input  logic              In_Ready,
    output logic              Out_A,
    output logic              Out_B,
    output logic              Out_C,
    output logic              Out_Valid,
    output logic [ITER_W-1:0] Out_Iter,
    output logic              Out_Busy,
    output logic              Out_Done
);

    // An all-zero seed would lock the LFSR, so it is swapped for the default.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? DEFAULT_SEED : SEED;

    stim_state_t       state_q, state_d;
    logic [ITER_W-1:0] rem_q, rem_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        vec_q, vec_d;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [LFSR_W-1:0] lfsr_cur;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [2:0]        vec_sel;

`ifdef MUX2_STIM_EXHAUSTIVE_EN
    // Indices 0..7 belong to the binary sweep.
    function automatic logic in_sweep(input logic [ITER_W-1:0] idx);
        return (32'(idx) < 32'd8);
    endfunction
`endif

    mux2_lfsr u_lfsr (
        .clk     (In_Clk),
        .rst     (In_Rst),
        .load    (lfsr_load),
        .seed    (SEED_EFF),
        .advance (lfsr_adv),
        .state   (lfsr_cur)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        iter_d    = iter_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (In_Start) begin
                    rem_d     = In_Num_Iter;
                    iter_d    = '0;
                    lfsr_load = 1'b1;
                    state_d   = (In_Num_Iter != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Out_Valid is always high in RUN, so In_Ready alone is the accept.
                if (In_Ready) begin
                    iter_d = iter_q + ITER_W'(1);
                    rem_d  = rem_q - ITER_W'(1);
`ifdef MUX2_STIM_EXHAUSTIVE_EN
                    // Sweep vectors do not consume LFSR states.
                    lfsr_adv = !in_sweep(iter_q);
`else
                    lfsr_adv = 1'b1;
`endif
                    if (rem_q == ITER_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The vector register is loaded with what the LFSR will hold after
        // this edge, so vector and LFSR stay aligned without an extra cycle.
        if (lfsr_load) begin
            lfsr_nxt = SEED_EFF;
        end else if (lfsr_adv) begin
            lfsr_nxt = lfsr_step(lfsr_cur);
        end else begin
            lfsr_nxt = lfsr_cur;
        end

        vec_sel = lfsr_nxt[2:0];
`ifdef MUX2_STIM_EXHAUSTIVE_EN
        if (in_sweep(iter_d)) begin
            vec_sel = iter_d[2:0];
        end
`endif

        // Outputs are a registered image of the next state.
        valid_d = (state_d == RUN);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        vec_d   = valid_d ? vec_sel : 3'b000;
    end

    // Upper LFSR bits steer the sequence but never reach the vector.
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_nxt[LFSR_W-1:3];

    always_ff @(posedge In_Clk) begin
        if (In_Rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            iter_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vec_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            iter_q  <= iter_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vec_q   <= vec_d;
        end
    end

    assign Out_A     = vec_q[2];
    assign Out_B     = vec_q[1];
    assign Out_C     = vec_q[0];
    assign Out_Valid = valid_q;
    assign Out_Iter  = iter_q;
    assign Out_Busy  = busy_q;
    assign Out_Done  = done_q;

endmodule

// File: tb/tb_mux2_stim_gen.sv
// Purpose : directed self-checking bench for mux2_stim_gen.
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: In_Ready dropped for a 3-cycle stall in one scenario.
module tb_mux2_stim_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_iter = 8'd0;
    logic       ready = 1'b1;
    logic       out_a, out_b, out_c, out_valid, out_busy, out_done;
    logic [7:0] out_iter;

    int n_tests = 0;
    int n_fail  = 0;

    // Hand-derived LFSR vectors from seed 8'h01:
    // 01,02,04,08,11,23,47,8E -> low three bits below.
    logic [2:0] lfsr_tab [8] = '{3'b001, 3'b010, 3'b100, 3'b000,
                                 3'b001, 3'b011, 3'b111, 3'b110};

    mux2_stim_gen #(.ITER_W(8), .SEED(8'h01)) dut (
        .In_Clk      (clk),
        .In_Rst      (rst),
        .In_Start    (start),
        .In_Num_Iter (num_iter),
        .In_Ready    (ready),
        .Out_A       (out_a),
        .Out_B       (out_b),
        .Out_C       (out_c),
        .Out_Valid   (out_valid),
        .Out_Iter    (out_iter),
        .Out_Busy    (out_busy),
        .Out_Done    (out_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_vec(input int i);
`ifdef MUX2_STIM_EXHAUSTIVE_EN
        logic [31:0] iv;
        iv = 32'(i);
        if (i < 8) return iv[2:0];
        return lfsr_tab[i-8];
`else
        return lfsr_tab[i];
`endif
    endfunction

    task automatic start_run(input int n);
        logic [31:0] nv;
        nv       = 32'(n);
        start    = 1'b1;
        num_iter = nv[7:0];
        tick();
        start    = 1'b0;
    endtask

    task automatic check_vec(input int i);
        check("valid", 32'(out_valid), 32'd1);
        check("vec",   32'({out_a, out_b, out_c}), 32'(exp_vec(i)));
        check("iter",  32'(out_iter), 32'(i));
    endtask

    // Full run with ready held high; Out_Done expected N edges after start.
    task automatic run_nominal(input int n);
        ready = 1'b1;
        start_run(n);
        for (int i = 0; i < n; i++) begin
            check_vec(i);
            check("busy_run", 32'(out_busy), 32'd1);
            tick();
        end
        check("done_pulse", 32'(out_done), 32'd1);
        check("valid_at_done", 32'(out_valid), 32'd0);
        check("busy_at_done", 32'(out_busy), 32'd1);
        check("iter_final", 32'(out_iter), 32'(n));
        tick();
        check("done_one_cycle", 32'(out_done), 32'd0);
        check("busy_back_idle", 32'(out_busy), 32'd0);
    endtask

    initial begin
        // Reset held for two cycles while idle.
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(out_busy),  32'd0);
        check("rst_done",  32'(out_done),  32'd0);
        check("rst_iter",  32'(out_iter),  32'd0);
        check("rst_vec",   32'({out_a, out_b, out_c}), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(out_busy), 32'd0);

        // Nominal run, N=5.
        run_nominal(5);

        // Stall at iteration 1 for three cycles, N=3.
        ready = 1'b1;
        start_run(3);
        check_vec(0);
        tick();
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_vec(1);
            tick();
        end
        check_vec(1);
        ready = 1'b1;
        tick();
        check_vec(2);
        tick();
        check("stall_done", 32'(out_done), 32'd1);
        check("stall_count", 32'(out_iter), 32'd3);
        tick();

        // Zero iterations.
        start_run(0);
        check("zero_done", 32'(out_done), 32'd1);
        check("zero_valid", 32'(out_valid), 32'd0);
        check("zero_busy", 32'(out_busy), 32'd1);
        tick();
        check("zero_done_off", 32'(out_done), 32'd0);
        check("zero_valid_off", 32'(out_valid), 32'd0);
        check("zero_idle", 32'(out_busy), 32'd0);

        // Start pulsed during RUN must be ignored.
        start_run(4);
        for (int i = 0; i < 4; i++) begin
            check_vec(i);
            if (i == 1) begin
                start    = 1'b1;
                num_iter = 8'd1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("ign_done", 32'(out_done), 32'd1);
        check("ign_count", 32'(out_iter), 32'd4);
        tick();
        check("ign_no_restart", 32'(out_busy), 32'd0);

        // Reset in the middle of a 6-vector run.
        start_run(6);
        tick();
        tick();
        check_vec(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy",  32'(out_busy),  32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_iter",  32'(out_iter),  32'd0);
        check("midrst_vec",   32'({out_a, out_b, out_c}), 32'd0);
        for (int k = 0; k < 6; k++) begin
            check("midrst_no_done", 32'(out_done), 32'd0);
            tick();
        end
        // Restart replays from the seed.
        run_nominal(2);

`ifdef MUX2_STIM_EXHAUSTIVE_EN
        run_nominal(10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
